// File: rtl/sqrt_pkg.sv
// -----------------------------------------------------------------------------
// sqrt_pkg
// Shared definitions for the iterative square-root block:
//   - sqrt_state_e : handshake/compute FSM states (IDLE, CALC, DONE)
//   - cnt_width()  : width of the step counter for a given root width
// -----------------------------------------------------------------------------
package sqrt_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sqrt_state_e;

  // Step counter must hold 0 .. r_w-1; keep at least one bit.
  function automatic int cnt_width(input int r_w);
    if (r_w > 32'sd1) begin
      return $clog2(r_w);
    end else begin
      return 32'sd1;
    end
  endfunction

endpackage

// File: rtl/sqrt_step.sv
// -----------------------------------------------------------------------------
// sqrt_step
// One restoring digit of the square root: brings down two radicand bits,
// trial-subtracts {q, 01} and decides the next root bit. Purely combinational.
// Ports:
//   r      : current partial remainder (R_W+1 bits)
//   q      : current partial root (R_W bits)
//   bits   : next two radicand bits, MSB first
//   r_next : remainder after this digit
//   q_next : root after this digit (new bit shifted in at the LSB)
// -----------------------------------------------------------------------------
module sqrt_step #(
  parameter int R_W = 8
) (
  input  logic [R_W:0]   r,
  input  logic [R_W-1:0] q,
  input  logic [1:0]     bits,
  output logic [R_W:0]   r_next,
  output logic [R_W-1:0] q_next
);

  logic [R_W+2:0] cand;
  logic [R_W+2:0] trial;
  logic [R_W:0]   diff;

  // Trial subtraction; the comparison on the full-width operands gives the
  // sign of the difference, and only the low R_W+1 bits of a non-negative
  // difference can be non-zero, so the subtraction itself is kept narrow.
  always_comb begin
    cand  = {r, bits};
    trial = {1'b0, q, 2'b01};
    diff  = cand[R_W:0] - trial[R_W:0];
    if (cand >= trial) begin
      r_next = diff;
      q_next = {q[R_W-2:0], 1'b1};
    end else begin
      r_next = cand[R_W:0];
      q_next = {q[R_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/sqrt_iter_hs.sv
// -----------------------------------------------------------------------------
// sqrt_iter_hs
// Iterative integer square root with valid/ready handshakes. Returns
// floor(sqrt(dt_i)) and dt_i - root^2, one root bit per enabled cycle,
// fixed latency of R_W compute cycles regardless of the radicand.
// Ports:
//   clk_i        : clock, rising edge
//   rstn_i       : synchronous active-low reset
//   enb_i        : global enable, low stalls acceptance and computation
//   in_valid_i   : radicand valid        in_ready_o  : block can accept
//   dt_i         : radicand (DATA_W)
//   out_valid_o  : result valid          out_ready_i : consumer accepts
//   root_o       : root (R_W)            rem_o       : remainder (R_W+1)
//   busy_o       : FSM not idle
// -----------------------------------------------------------------------------
module sqrt_iter_hs
  import sqrt_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  enb_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_W-1:0]     dt_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_W/2-1:0]   root_o,
  output logic [DATA_W/2:0]     rem_o,
  output logic                  busy_o
);

  localparam int R_W   = DATA_W / 2;
  localparam int CNT_W = cnt_width(R_W);

  if (((DATA_W % 2) != 0) || (DATA_W < 4)) begin : g_bad_width
    $error("sqrt_iter_hs: DATA_W must be even and at least 4");
  end

  sqrt_state_e       state;
  sqrt_state_e       state_next;
  logic [DATA_W-1:0] rad;
  logic [R_W-1:0]    q;
  logic [R_W:0]      r;
  logic [CNT_W-1:0]  cnt;
  logic [R_W-1:0]    q_step;
  logic [R_W:0]      r_step;
  logic              load;
  logic              step;
  logic              finish;

  sqrt_step #(.R_W(R_W)) u_step (
    .r      (r),
    .q      (q),
    .bits   (rad[DATA_W-1:DATA_W-2]),
    .r_next (r_step),
    .q_next (q_step)
  );

  // Next-state and datapath control decode.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid_i && enb_i) begin
          load       = 1'b1;
          state_next = CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (enb_i) begin
          step = 1'b1;
          if (cnt == CNT_W'(R_W - 1)) begin
            finish     = 1'b1;
            state_next = DONE;
          end else begin
            state_next = CALC;
          end
        end else begin
          state_next = CALC;
        end
      end
      DONE: begin
        // Output transfer deliberately ignores enb_i.
        if (out_ready_i) begin
          state_next = IDLE;
        end else begin
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register, working registers and registered results.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state  <= IDLE;
      rad    <= '0;
      q      <= '0;
      r      <= '0;
      cnt    <= '0;
      root_o <= '0;
      rem_o  <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        rad <= dt_i;
        q   <= '0;
        r   <= '0;
        cnt <= '0;
      end else if (step) begin
        rad <= {rad[DATA_W-3:0], 2'b00};
        q   <= q_step;
        r   <= r_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        root_o <= q_step;
        rem_o  <= r_step;
      end
    end
  end

  // rstn_i gates in_ready_o so nothing looks acceptable during reset.
  assign in_ready_o  = rstn_i & enb_i & (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_sqrt_iter_hs.sv
// -----------------------------------------------------------------------------
// tb_sqrt_iter_hs
// Self-checking bench for sqrt_iter_hs. Instantiates a 16-bit and an 8-bit
// DUT sharing clock, reset and enable; a selector routes the stimulus to one
// of them. Expected roots come from a plain integer search, not from the
// digit-by-digit algorithm.
// -----------------------------------------------------------------------------
module tb_sqrt_iter_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        enb;
  logic        drv_valid;
  logic        drv_oready;
  logic [15:0] drv_dt;
  logic        use8;

  logic        in_valid16, in_ready16, out_valid16, busy16;
  logic [7:0]  root16;
  logic [8:0]  rem16;
  logic        in_valid8, in_ready8, out_valid8, busy8;
  logic [3:0]  root8;
  logic [4:0]  rem8;

  logic        cur_ready, cur_ov;
  logic [15:0] cur_root, cur_rem;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  assign in_valid16 = drv_valid & ~use8;
  assign in_valid8  = drv_valid & use8;
  assign cur_ready  = use8 ? in_ready8 : in_ready16;
  assign cur_ov     = use8 ? out_valid8 : out_valid16;
  assign cur_root   = use8 ? {12'd0, root8} : {8'd0, root16};
  assign cur_rem    = use8 ? {11'd0, rem8} : {7'd0, rem16};

  sqrt_iter_hs #(.DATA_W(16)) dut16 (
    .clk_i(clk), .rstn_i(rstn), .enb_i(enb),
    .in_valid_i(in_valid16), .in_ready_o(in_ready16), .dt_i(drv_dt),
    .out_valid_o(out_valid16), .out_ready_i(drv_oready),
    .root_o(root16), .rem_o(rem16), .busy_o(busy16)
  );

  sqrt_iter_hs #(.DATA_W(8)) dut8 (
    .clk_i(clk), .rstn_i(rstn), .enb_i(enb),
    .in_valid_i(in_valid8), .in_ready_o(in_ready8), .dt_i(drv_dt[7:0]),
    .out_valid_o(out_valid8), .out_ready_i(drv_oready),
    .root_o(root8), .rem_o(rem8), .busy_o(busy8)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: largest r with r*r <= x.
  function automatic int ref_root(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Present x, wait for acceptance, then count negedges until out_valid.
  // lat is -1 on timeout. Drains the result if drv_oready is high.
  task automatic op(input logic [15:0] x, output int lat, output int r, output int m);
    int n;
    n = 0;
    drv_dt = x;
    drv_valid = 1'b1;
    while (!cur_ready && n < 50) begin @(negedge clk); n++; end
    if (!cur_ready) begin
      drv_valid = 1'b0; lat = -1; r = -1; m = -1;
      return;
    end
    @(negedge clk);
    drv_valid = 1'b0;
    lat = 0;
    while (!cur_ov && lat < 60) begin @(negedge clk); lat++; end
    if (!cur_ov) lat = -1;
    r = int'(cur_root);
    m = int'(cur_rem);
    if (drv_oready) @(negedge clk);
  endtask

  task automatic test_reset();
    rstn = 1'b0; enb = 1'b1; drv_valid = 1'b0; drv_oready = 1'b1; drv_dt = 16'd0; use8 = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if ({in_ready16, out_valid16, busy16, root16, rem16} !== 20'd0) begin
      mismatched++;
      $display("FAIL reset16: got rdy=%0b ov=%0b busy=%0b root=%0d rem=%0d want all 0",
               in_ready16, out_valid16, busy16, root16, rem16);
    end
    compared++;
    if ({in_ready8, out_valid8, busy8, root8, rem8} !== 12'd0) begin
      mismatched++;
      $display("FAIL reset8: got rdy=%0b ov=%0b busy=%0b root=%0d rem=%0d want all 0",
               in_ready8, out_valid8, busy8, root8, rem8);
    end
    rstn = 1'b1;
    @(negedge clk);
    compared++;
    if ({in_ready16, in_ready8} !== 2'b11) begin
      mismatched++;
      $display("FAIL ready_after_reset: got %b want 11", {in_ready16, in_ready8});
    end
  endtask

  task automatic test_directed16();
    int xs[4] = '{0, 1, 200, 65535};
    int er[4] = '{0, 1, 14, 255};
    int em[4] = '{0, 0, 4, 510};
    int lat, r, m;
    use8 = 1'b0; drv_oready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op(16'(xs[i]), lat, r, m);
      compared++;
      if (lat != 8 || r != er[i] || m != em[i] || busy16 !== 1'b0) begin
        mismatched++;
        $display("FAIL directed16 x=%0d: got root=%0d rem=%0d lat=%0d busy=%0b want %0d %0d 8 0",
                 xs[i], r, m, lat, busy16, er[i], em[i]);
      end
    end
  endtask

  task automatic test_directed8();
    int xs[3] = '{144, 143, 255};
    int er[3] = '{12, 11, 15};
    int em[3] = '{0, 22, 30};
    int lat, r, m;
    use8 = 1'b1; drv_oready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      op(16'(xs[i]), lat, r, m);
      compared++;
      if (lat != 4 || r != er[i] || m != em[i]) begin
        mismatched++;
        $display("FAIL directed8 x=%0d: got root=%0d rem=%0d lat=%0d want %0d %0d 4",
                 xs[i], r, m, lat, er[i], em[i]);
      end
    end
  endtask

  task automatic test_sweep8();
    int lat, r, m, er;
    use8 = 1'b1; drv_oready = 1'b1;
    for (int x = 0; x < 256; x++) begin
      op(16'(x), lat, r, m);
      er = ref_root(x);
      compared++;
      if (lat != 4 || r != er || m != x - er * er) begin
        mismatched++;
        $display("FAIL sweep8 x=%0d: got root=%0d rem=%0d lat=%0d want %0d %0d 4",
                 x, r, m, lat, er, x - er * er);
      end
    end
  endtask

  task automatic test_random16();
    int lat, r, m, er, x;
    use8 = 1'b0; drv_oready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 65535));
      op(16'(x), lat, r, m);
      er = ref_root(x);
      compared++;
      if (lat != 8 || r != er || m != x - er * er) begin
        mismatched++;
        $display("FAIL random16 x=%0d: got root=%0d rem=%0d lat=%0d want %0d %0d 8",
                 x, r, m, lat, er, x - er * er);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, r, m, er, x;
    logic [7:0] snap_root;
    logic [8:0] snap_rem;
    use8 = 1'b0; drv_oready = 1'b0;
    x = int'($urandom_range(1000, 65535));
    op(16'(x), lat, r, m);
    er = ref_root(x);
    compared++;
    if (lat != 8 || r != er || m != x - er * er) begin
      mismatched++;
      $display("FAIL bp_result x=%0d: got root=%0d rem=%0d lat=%0d want %0d %0d 8",
               x, r, m, lat, er, x - er * er);
    end
    snap_root = 8'(er);
    snap_rem  = 9'(x - er * er);
    for (int i = 0; i < 5; i++) begin
      drv_valid = (i % 2 == 0);
      drv_dt = 16'($urandom);
      @(negedge clk);
      compared++;
      if (out_valid16 !== 1'b1 || in_ready16 !== 1'b0 || root16 !== snap_root || rem16 !== snap_rem) begin
        mismatched++;
        $display("FAIL bp_hold cycle %0d: got ov=%0b rdy=%0b root=%0d rem=%0d want 1 0 %0d %0d",
                 i, out_valid16, in_ready16, root16, rem16, snap_root, snap_rem);
      end
    end
    drv_valid = 1'b0;
    drv_oready = 1'b1;
    @(negedge clk);
    compared++;
    if (out_valid16 !== 1'b0 || busy16 !== 1'b0 || root16 !== snap_root || rem16 !== snap_rem) begin
      mismatched++;
      $display("FAIL bp_release: got ov=%0b busy=%0b root=%0d rem=%0d want 0 0 %0d %0d",
               out_valid16, busy16, root16, rem16, snap_root, snap_rem);
    end
  endtask

  task automatic test_stall();
    int lat, n;
    logic [7:0] snap_root;
    logic [8:0] snap_rem;
    use8 = 1'b0; drv_oready = 1'b1;
    n = 0;
    drv_dt = 16'd1000;
    drv_valid = 1'b1;
    while (!in_ready16 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    drv_valid = 1'b0;
    lat = 0;
    repeat (2) begin @(negedge clk); lat++; end
    enb = 1'b0;
    snap_root = root16;
    snap_rem  = rem16;
    repeat (3) begin
      @(negedge clk); lat++;
      compared++;
      if (out_valid16 !== 1'b0 || busy16 !== 1'b1 || in_ready16 !== 1'b0 ||
          root16 !== snap_root || rem16 !== snap_rem) begin
        mismatched++;
        $display("FAIL stall_hold: got ov=%0b busy=%0b rdy=%0b root=%0d rem=%0d want 0 1 0 %0d %0d",
                 out_valid16, busy16, in_ready16, root16, rem16, snap_root, snap_rem);
      end
    end
    enb = 1'b1;
    while (!out_valid16 && lat < 60) begin @(negedge clk); lat++; end
    compared++;
    if (out_valid16 !== 1'b1 || lat != 11 || root16 !== 8'd31 || rem16 !== 9'd39) begin
      mismatched++;
      $display("FAIL stall_result: got ov=%0b lat=%0d root=%0d rem=%0d want 1 11 31 39",
               out_valid16, lat, root16, rem16);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, r, m, n, seen;
    use8 = 1'b0; drv_oready = 1'b1;
    n = 0;
    drv_dt = 16'd50000;
    drv_valid = 1'b1;
    while (!in_ready16 && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    drv_valid = 1'b0;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    compared++;
    if (out_valid16 !== 1'b0 || busy16 !== 1'b0 || root16 !== 8'd0 || rem16 !== 9'd0) begin
      mismatched++;
      $display("FAIL reset_mid: got ov=%0b busy=%0b root=%0d rem=%0d want 0 0 0 0",
               out_valid16, busy16, root16, rem16);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid16 === 1'b1 || busy16 === 1'b1) seen++;
    end
    compared++;
    if (seen != 0) begin
      mismatched++;
      $display("FAIL reset_mid_quiet: got %0d active cycles want 0", seen);
    end
    op(16'd49, lat, r, m);
    compared++;
    if (lat != 8 || r != 7 || m != 0) begin
      mismatched++;
      $display("FAIL reset_mid_49: got root=%0d rem=%0d lat=%0d want 7 0 8", r, m, lat);
    end
  endtask

  task automatic test_back_to_back();
    int exp_root[$];
    int exp_rem[$];
    int accepts, got, last_acc, cycles, x, er;
    bit accepted_now;
    use8 = 1'b0; drv_oready = 1'b1;
    accepts = 0; got = 0; last_acc = 0; cycles = 0;
    drv_dt = 16'($urandom);
    drv_valid = 1'b1;
    while (got < 6 && cycles < 200) begin
      if (out_valid16) begin
        compared++;
        if (exp_root.size() == 0 || root16 !== exp_root[0] || rem16 !== exp_rem[0]) begin
          mismatched++;
          $display("FAIL b2b_result %0d: got root=%0d rem=%0d want %0d %0d", got, root16, rem16,
                   (exp_root.size() != 0) ? exp_root[0] : -1, (exp_rem.size() != 0) ? exp_rem[0] : -1);
        end
        if (exp_root.size() != 0) begin
          void'(exp_root.pop_front());
          void'(exp_rem.pop_front());
        end
        got++;
      end
      accepted_now = drv_valid && in_ready16;
      if (accepted_now) begin
        if (accepts > 0) begin
          compared++;
          if (cyc - last_acc != 10) begin
            mismatched++;
            $display("FAIL b2b_period: got %0d cycles want 10", cyc - last_acc);
          end
        end
        last_acc = cyc;
        x = int'(drv_dt);
        er = ref_root(x);
        exp_root.push_back(er);
        exp_rem.push_back(x - er * er);
        accepts++;
      end
      @(negedge clk);
      cycles++;
      if (accepted_now) begin
        if (accepts < 6) drv_dt = 16'($urandom);
        else drv_valid = 1'b0;
      end
    end
    drv_valid = 1'b0;
    compared++;
    if (got != 6 || accepts != 6 || exp_root.size() != 0) begin
      mismatched++;
      $display("FAIL b2b_count: got results=%0d accepts=%0d pending=%0d want 6 6 0",
               got, accepts, exp_root.size());
    end
  endtask

  initial begin
    test_reset();
    test_directed16();
    test_directed8();
    test_sweep8();
    test_random16();
    test_backpressure();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
    $fatal(1, "watchdog expired");
  end

endmodule
